branch_resolve: RTL

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/branch_resolve_pkg.sv | 26 ++
 rtl/pred_queue.sv | 77 +++++++
 rtl/branch_resolve.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/branch_resolve_pkg.sv
// Shared types and ISA widths for the branch-resolution slice.
// PC/BTB widths come from the ISA defines below (mirrors opcodes.v).
`ifndef BRANCH_RESOLVE_ISA_DEFINES
`define BRANCH_RESOLVE_ISA_DEFINES
`define WORD_SIZE 16
`define BTB_INDEX_W 8
`define BTB_TAG_W 8
`endif

package branch_resolve_pkg;

    localparam int WORD_W    = `WORD_SIZE;
    localparam int BTB_IDX_W = `BTB_INDEX_W;
    localparam int BTB_TAG_W = `BTB_TAG_W;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] pred_next;
    } pred_entry_t;

    // Fall-through address, wraps modulo 2^WORD_W.
    function automatic logic [WORD_W-1:0] seq_next(input logic [WORD_W-1:0] pc);
        return pc + WORD_W'(1);
    endfunction

endpackage

// File: rtl/pred_queue.sv
// Purpose: in-order queue of outstanding predictions with synchronous clear.
// Latency: head visible combinationally; push/pop take effect on the next edge.
// Backpressure: push while full is dropped unless a pop frees the slot the same cycle.
module pred_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    always_comb begin
        full     = (cnt_q == FULL_CNT);
        empty    = (cnt_q == '0);
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        // Clear wins over a same-cycle push: that entry belongs to the squashed path.
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    assign dout = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/branch_resolve.sv
// Purpose: check fetch predictions against ID resolution; flush, redirect, predictor/BTB update.
// Latency: one cycle from pop to registered strobes; stall freezes queue and drops strobes.
// Backpressure: none upstream; push while full sets sticky err_overflow. BRANCH_STATS_EN adds counters.
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 pred_valid,
    input  logic [WORD_W-1:0]    pred_PC,
    input  logic [WORD_W-1:0]    pred_next_PC,
    input  logic                 stall,
    input  logic                 res_valid,
    input  logic                 res_is_BJ,
    input  logic                 res_taken,
    input  logic [WORD_W-1:0]    res_target,
    output logic                 flush,
    output logic [WORD_W-1:0]    redirect_PC,
    output logic                 update_valid,
    output logic                 update_taken,
    output logic                 btb_we,
    output logic [BTB_IDX_W-1:0] btb_index,
    output logic [BTB_TAG_W-1:0] btb_tag,
    output logic [WORD_W-1:0]    btb_target,
    output logic                 q_full,
    output logic                 q_empty,
    output logic                 err_overflow
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]          branch_count,
    output logic [15:0]          mispredict_count
`endif
);
    pred_entry_t push_entry, head;
    logic        push_req, pop_ok, overflow;
    logic        taken_bj, mispredict;
    logic [WORD_W-1:0] actual_next;

    logic                 flush_q, flush_d;
    logic [WORD_W-1:0]    redirect_pc_q, redirect_pc_d;
    logic                 update_valid_q, update_valid_d;
    logic                 update_taken_q, update_taken_d;
    logic                 btb_we_q, btb_we_d;
    logic [BTB_IDX_W-1:0] btb_index_q, btb_index_d;
    logic [BTB_TAG_W-1:0] btb_tag_q, btb_tag_d;
    logic [WORD_W-1:0]    btb_target_q, btb_target_d;
    logic                 err_overflow_q, err_overflow_d;

    pred_queue #(
        .DEPTH (DEPTH),
        .W     ($bits(pred_entry_t))
    ) u_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_req),
        .pop     (pop_ok),
        .clear   (mispredict),
        .din     (push_entry),
        .dout    (head),
        .full    (q_full),
        .empty   (q_empty)
    );

    always_comb begin
        push_entry.pc        = pred_PC;
        push_entry.pred_next = pred_next_PC;
        push_req    = pred_valid & ~stall;
        pop_ok      = res_valid & ~stall & ~q_empty;
        overflow    = push_req & q_full & ~pop_ok;
        taken_bj    = res_is_BJ & res_taken;
        actual_next = taken_bj ? res_target : seq_next(head.pc);
        mispredict  = pop_ok & (actual_next != head.pred_next);

        flush_d        = mispredict;
        redirect_pc_d  = mispredict ? actual_next : redirect_pc_q;
        update_valid_d = pop_ok & res_is_BJ;
        update_taken_d = pop_ok & res_is_BJ & res_taken;
        btb_we_d       = pop_ok & taken_bj;
        btb_index_d    = btb_index_q;
        btb_tag_d      = btb_tag_q;
        btb_target_d   = btb_target_q;
        if (pop_ok & taken_bj) begin
            btb_index_d  = head.pc[BTB_IDX_W-1:0];
            btb_tag_d    = head.pc[WORD_W-1 -: BTB_TAG_W];
            btb_target_d = res_target;
        end
        err_overflow_d = err_overflow_q | overflow;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flush_q        <= 1'b0;
            redirect_pc_q  <= '0;
            update_valid_q <= 1'b0;
            update_taken_q <= 1'b0;
            btb_we_q       <= 1'b0;
            btb_index_q    <= '0;
            btb_tag_q      <= '0;
            btb_target_q   <= '0;
            err_overflow_q <= 1'b0;
        end else begin
            flush_q        <= flush_d;
            redirect_pc_q  <= redirect_pc_d;
            update_valid_q <= update_valid_d;
            update_taken_q <= update_taken_d;
            btb_we_q       <= btb_we_d;
            btb_index_q    <= btb_index_d;
            btb_tag_q      <= btb_tag_d;
            btb_target_q   <= btb_target_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    assign flush        = flush_q;
    assign redirect_PC  = redirect_pc_q;
    assign update_valid = update_valid_q;
    assign update_taken = update_taken_q;
    assign btb_we       = btb_we_q;
    assign btb_index    = btb_index_q;
    assign btb_tag      = btb_tag_q;
    assign btb_target   = btb_target_q;
    assign err_overflow = err_overflow_q;

`ifdef BRANCH_STATS_EN
    logic [15:0] branch_cnt_q, branch_cnt_d;
    logic [15:0] mispredict_cnt_q, mispredict_cnt_d;

    always_comb begin
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (pop_ok & res_is_BJ & (branch_cnt_q != 16'hFFFF)) begin
            branch_cnt_d = branch_cnt_q + 16'd1;
        end
        if (mispredict & (mispredict_cnt_q != 16'hFFFF)) begin
            mispredict_cnt_d = mispredict_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign branch_count     = branch_cnt_q;
    assign mispredict_count = mispredict_cnt_q;
`endif

endmodule
